// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, length-width helper and reset values for the sequence detector.
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  localparam state_t RST_STATE = IDLE;
  localparam logic RST_MATCH = 1'b0;
  localparam logic RST_CFG_ERR = 1'b0;
  localparam logic RST_OVERLAP = 1'b0;
endpackage

// File: rtl/seq_det_match_counter.sv
// seq_det_match_counter: saturating event counter with synchronous clear (clear beats increment).
module seq_det_match_counter import seq_det_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with registered Moore match output.
// Match counter is built only when SEQ_DETECTOR_PARAM_COUNT_EN is defined.
module seq_detector_param import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count,
  input  logic               count_clr
);
  state_t state;
  logic [MAX_LEN-1:0] hist, pattern, hist_nxt, mask;
  logic [LEN_W-1:0] len, fill, fill_nxt;
  logic overlap, cfg_ok, accept, hit;
  assign cfg_ok = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
  assign accept = in_valid && state != IDLE;
  assign hist_nxt = (hist << 1) | MAX_LEN'(in_bit);
  assign fill_nxt = fill == len ? fill : fill + LEN_W'(1);
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
  end
  // Bits of hist above len are masked out, so stale history never blocks a match.
  assign hit = accept && fill_nxt == len && ((hist_nxt ^ pattern) & mask) == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= RST_STATE;
      match <= RST_MATCH;
      cfg_err <= RST_CFG_ERR;
      overlap <= RST_OVERLAP;
      pattern <= '0;
      len <= '0;
      hist <= '0;
      fill <= '0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_load && cfg_ok) begin
        pattern <= cfg_pattern;
        len <= cfg_len;
        overlap <= cfg_overlap;
        hist <= '0;
        fill <= '0;
        state <= ARMED;
        match <= 1'b0;
      end else if (!cfg_load && state != IDLE) begin
        if (accept) begin
          hist <= hist_nxt;
          fill <= hit && !overlap ? '0 : fill_nxt;
        end
        state <= hit ? HIT : ARMED;
        match <= hit;
      end
    end
`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
  seq_det_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .reset_n(reset_n),
    .clr(count_clr),
    .inc(hit && !cfg_load),
    .count(match_count)
  );
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench; a second instance with CNT_W=2 checks saturation.
module tb_seq_detector_param;
`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 0, reset_n = 0, cfg_load = 0, cfg_overlap = 0, in_valid = 0, in_bit = 0, count_clr = 0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic match, cfg_err, match2, cfg_err2;
  logic [15:0] match_count;
  logic [1:0] match_count2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
    .match(match), .cfg_err(cfg_err), .match_count(match_count), .count_clr(count_clr)
  );
  seq_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
    .match(match2), .cfg_err(cfg_err2), .match_count(match_count2), .count_clr(count_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    cfg_load = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    tick();
    cfg_load = 0;
  endtask

  task automatic send(input logic b);
    in_valid = 1; in_bit = b;
    tick();
    in_valid = 0;
  endtask

  task automatic clear_counts();
    count_clr = 1;
    tick();
    count_clr = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    checks += 3;
    if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    if (match_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", match_count); end
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      checks++;
      if (match !== 1'b0) begin failures++; $display("FAIL idle_ignore bit%0d got=%b exp=0", i, match); end
    end
  endtask

  task automatic run_1101(input logic ov, input logic [6:0] exp, input string name);
    logic [6:0] s;
    s = 7'b1101101;
    load(8'b1101, 4'd4, ov);
    clear_counts();
    for (int i = 0; i < 7; i++) begin
      send(s[6-i]);
      checks++;
      if (match !== exp[6-i]) begin failures++; $display("FAIL %s bit%0d match got=%b exp=%b", name, i + 1, match, exp[6-i]); end
    end
  endtask

  task automatic test_overlap();
    run_1101(1'b1, 7'b0001001, "overlap");
    checks += 2;
    if (match_count !== (CE ? 16'd2 : 16'd0)) begin failures++; $display("FAIL overlap_count got=%0d exp=%0d", match_count, CE ? 2 : 0); end
    if (match_count2 !== (CE ? 2'd2 : 2'd0)) begin failures++; $display("FAIL overlap_count2 got=%0d exp=%0d", match_count2, CE ? 2 : 0); end
  endtask

  task automatic test_non_overlap();
    run_1101(1'b0, 7'b0001000, "nonoverlap");
    checks++;
    if (match_count !== (CE ? 16'd1 : 16'd0)) begin failures++; $display("FAIL nonoverlap_count got=%0d exp=%0d", match_count, CE ? 1 : 0); end
  endtask

  task automatic test_len1_saturate();
    load(8'h01, 4'd1, 1'b1);
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      checks++;
      if (match !== 1'b1) begin failures++; $display("FAIL len1_hold bit%0d got=%b exp=1", i, match); end
    end
    tick();
    checks += 3;
    if (match !== 1'b0) begin failures++; $display("FAIL len1_drop got=%b exp=0", match); end
    if (match_count !== (CE ? 16'd5 : 16'd0)) begin failures++; $display("FAIL len1_count got=%0d exp=%0d", match_count, CE ? 5 : 0); end
    if (match_count2 !== (CE ? 2'd3 : 2'd0)) begin failures++; $display("FAIL saturate_count2 got=%0d exp=%0d", match_count2, CE ? 3 : 0); end
  endtask

  task automatic test_count_clr();
    count_clr = 1; in_valid = 1; in_bit = 1;
    tick();
    count_clr = 0; in_valid = 0;
    checks += 3;
    if (match !== 1'b1) begin failures++; $display("FAIL clr_match got=%b exp=1", match); end
    if (match_count !== 16'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", match_count); end
    if (match_count2 !== 2'd0) begin failures++; $display("FAIL clr_wins2 got=%0d exp=0", match_count2); end
    send(1'b1);
    checks++;
    if (match_count !== (CE ? 16'd1 : 16'd0)) begin failures++; $display("FAIL clr_then_count got=%0d exp=%0d", match_count, CE ? 1 : 0); end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      load(8'h00, bad[k], 1'b0);
      checks++;
      if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse len=%0d got=%b exp=1", bad[k], cfg_err); end
      tick();
      checks++;
      if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear len=%0d got=%b exp=0", bad[k], cfg_err); end
    end
    send(1'b1);
    checks++;
    if (match !== 1'b1) begin failures++; $display("FAIL old_pattern_kept got=%b exp=1", match); end
  endtask

  task automatic test_load_with_bit();
    in_valid = 1; in_bit = 1;
    load(8'h01, 4'd1, 1'b1);
    in_valid = 0;
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL load_discards_bit got=%b exp=0", match); end
    send(1'b1);
    checks++;
    if (match !== 1'b1) begin failures++; $display("FAIL load_then_bit got=%b exp=1", match); end
  endtask

  task automatic test_upper_dont_care();
    load(8'hF5, 4'd3, 1'b0);
    send(1'b1); send(1'b0);
    checks++;
    if (match !== 1'b0) begin failures++; $display("FAIL len3_early got=%b exp=0", match); end
    send(1'b1);
    checks++;
    if (match !== 1'b1) begin failures++; $display("FAIL len3_match got=%b exp=1", match); end
  endtask

  task automatic test_max_len();
    logic [7:0] p;
    p = 8'b10110011;
    load(p, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(p[7-i]);
      checks++;
      if (match !== (i == 7)) begin failures++; $display("FAIL len8 bit%0d got=%b exp=%b", i + 1, match, i == 7); end
    end
  endtask

  task automatic test_reset_mid();
    load(8'b1101, 4'd4, 1'b1);
    send(1'b1); send(1'b1); send(1'b0);
    #2 reset_n = 0;
    #1;
    checks += 2;
    if (match !== 1'b0) begin failures++; $display("FAIL async_reset_match got=%b exp=0", match); end
    if (match_count !== 16'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", match_count); end
    tick();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      checks++;
      if (match !== 1'b0) begin failures++; $display("FAIL post_reset_idle bit%0d got=%b exp=0", i, match); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_len1_saturate();
    test_count_clr();
    test_cfg_err();
    test_load_with_bit();
    test_upper_dont_care();
    test_max_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
